// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver.
// The RX pin passes through a two-flop synchronizer. A falling edge starts a frame, and
// each bit is sampled at mid-period. The received byte is presented with a sticky rdy
// flag, together with framing-error and overrun status.
`timescale 1ns/1ps

module uart_rx_core #(
    parameter int unsigned BAUD_DIV = 5208,  // clk cycles per bit; even, >= 8
    parameter int unsigned CNT_W    = 14     // must hold BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr
);

    localparam logic [CNT_W-1:0] BaudFull = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] BaudHalf = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [3:0]       StopIdx  = 4'd9;

    typedef enum logic [0:0] {
        StIdle,
        StRcv
    } state_e;

    // Synchronizer and edge-detect flops
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic rx_fall;

    // Frame FSM state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [CNT_W-1:0] baud_dec;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_done_q, frame_done_d;
    logic             stop_bit_q, stop_bit_d;
    logic             sample;

    // Host-visible result registers
    logic [7:0] rx_data_q, rx_data_d;
    logic       rdy_q, rdy_d;
    logic       frm_err_q, frm_err_d;
    logic       ovr_q, ovr_d;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    // The counter is loaded with BAUD_DIV/2 or BAUD_DIV. A sample fires on the cycle the
    // decrement reaches zero, so consecutive samples are exactly BAUD_DIV clocks apart.
    assign baud_dec = baud_cnt_q - CntOne;
    assign sample   = (state_q == StRcv) && (baud_dec == '0);

    // Frame FSM next state: start detection, mid-bit sampling, stop-bit capture
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        stop_bit_d   = stop_bit_q;

        unique case (state_q)
            StIdle: begin
                if (rx_fall) begin
                    state_d    = StRcv;
                    baud_cnt_d = BaudHalf;
                    bit_cnt_d  = '0;
                end
            end
            StRcv: begin
                if (sample) begin
                    baud_cnt_d = BaudFull;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if ((bit_cnt_q == 4'd0) && rx_s_q) begin
                        // The start bit was gone by mid-bit, so this was a glitch.
                        state_d = StIdle;
                    end else if (bit_cnt_q == StopIdx) begin
                        state_d      = StIdle;
                        frame_done_d = 1'b1;
                        stop_bit_d   = rx_s_q;
                    end else begin
                        // MSB-first-in: the start bit falls off the end, d0 lands in bit 0.
                        shift_d = {rx_s_q, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_dec;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            baud_cnt_q   <= BaudFull;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_done_q <= 1'b0;
            stop_bit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_done_q <= frame_done_d;
            stop_bit_q   <= stop_bit_d;
        end
    end

    // Status update. A host clear is applied first, and a completing frame then overrides it.
    always_comb begin
        rx_data_d = rx_data_q;
        rdy_d     = rdy_q;
        frm_err_d = frm_err_q;
        ovr_d     = ovr_q;

        if (clr_rdy) begin
            rdy_d     = 1'b0;
            frm_err_d = 1'b0;
            ovr_d     = 1'b0;
        end

        if (frame_done_q) begin
            if (stop_bit_q) begin
                rx_data_d = shift_q;
                rdy_d     = 1'b1;
                frm_err_d = 1'b0;
                // An acknowledge in the same cycle consumes the old byte, so it is not an overrun.
                ovr_d     = ovr_d | (rdy_q & ~clr_rdy);
            end else begin
                frm_err_d = 1'b1;
            end
        end
    end

    // Status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q <= 8'h00;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_data_q <= rx_data_d;
            rdy_q     <= rdy_d;
            frm_err_q <= frm_err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized scoreboard bench for uart_rx_core.
// A frame-level model predicts every change of {rx_data, rdy, frm_err, ovr}, and a
// monitor pops a prediction each time the outputs change.
`timescale 1ns/1ps

module tb_uart_rx_core;

    localparam int B   = 16;
    localparam int LAT = 2 + 1 + B / 2 + 9 * B + 1;

    typedef struct {
        logic [10:0] val;   // {rx_data, rdy, frm_err, ovr}
        bit          timed;
        int          lo;
        int          hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    // Reference model state: what the host should see after everything issued so far
    logic [7:0]  m_data = 8'h00;
    logic        m_rdy  = 1'b0;
    logic        m_frm  = 1'b0;
    logic        m_ovr  = 1'b0;
    logic [10:0] m_last = 11'h000;

    uart_rx_core #(
        .BAUD_DIV (B),
        .CNT_W    (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (rx),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got >= lo && got <= hi) passes++;
        else $display("FAIL %s: got cycle %0d, want %0d..%0d", name, got, lo, hi);
    endtask

    // Queue a prediction if the model state differs from the last predicted state
    task automatic push_state(input bit timed, input int start);
        exp_t        e;
        logic [10:0] nv;
        nv = {m_data, m_rdy, m_frm, m_ovr};
        if (nv !== m_last) begin
            e.val   = nv;
            e.timed = timed;
            e.lo    = start + LAT - 1;
            e.hi    = start + LAT + 1;
            exp_q.push_back(e);
            m_last  = nv;
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop, input int start);
        if (stop) begin
            m_ovr  = m_ovr | m_rdy;
            m_data = d;
            m_rdy  = 1'b1;
            m_frm  = 1'b0;
        end else begin
            m_frm = 1'b1;
        end
        push_state(1'b1, start);
    endtask

    task automatic model_clear();
        m_rdy = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        push_state(1'b0, 0);
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        model_clear();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 10-bit frame LSB first. Entered and left at 1 ns after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        model_frame(d, stop, cyc);
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            idle(B);
        end
        rx = 1'b1;
    endtask

    task automatic clr_pulse();
        model_clear();
        clr_rdy = 1'b1;
        idle(1);
        clr_rdy = 1'b0;
    endtask

    task automatic check_model(input string name);
        check(name, {21'd0, rx_data, rdy, frm_err, ovr}, {21'd0, m_data, m_rdy, m_frm, m_ovr});
    endtask

    // Monitor: each observed output change must match the oldest prediction
    initial begin
        logic [10:0] last;
        logic [10:0] cur;
        exp_t        e;
        wait (mon_en);
        last = {rx_data, rdy, frm_err, ovr};
        forever begin
            @(negedge clk);
            cur = {rx_data, rdy, frm_err, ovr};
            if (cur !== last) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_change: got %h, want %h", cur, last);
                end else begin
                    e = exp_q.pop_front();
                    check("outputs", {21'd0, cur}, {21'd0, e.val});
                    if (e.timed) check_range("latency", cyc, e.lo, e.hi);
                end
                last = cur;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        logic [7:0] d;
        logic       stop;
        int         gap;

        rst     = 1'b1;
        rx      = 1'b1;
        clr_rdy = 1'b0;
        idle(3);
        check("reset_rx_data", {24'd0, rx_data}, 32'h0);
        check("reset_flags", {29'd0, rdy, frm_err, ovr}, 32'h0);
        rst = 1'b0;
        idle(2);
        mon_en = 1'b1;
        idle(2);

        // Basic frame with a latency check
        send_frame(8'hA5, 1'b1);
        idle(4);
        clr_pulse();
        idle(4);

        // Back-to-back frames with no acknowledge in between cause an overrun
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        check_model("b2b_overrun");
        clr_pulse();
        idle(4);

        // Framing error leaves rx_data and rdy alone
        send_frame(8'h3C, 1'b0);
        idle(8);
        check_model("framing_error");

        // Short low glitch is rejected at mid start bit
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * B);
        check_model("glitch_unchanged");
        send_frame(8'h5A, 1'b1);
        idle(4);

        // Reset in the middle of bit 4 of 8'hC3, then a clean frame
        begin
            logic [9:0] f;
            f = {1'b1, 8'hC3, 1'b0};
            for (int i = 0; i < 4; i++) begin
                rx = f[i];
                idle(B);
            end
            rx = f[4];
            idle(B / 2);
            model_reset();
            rst = 1'b1;
            rx  = 1'b1;
            #1;
            check_model("async_reset");
            idle(2);
            rst = 1'b0;
            idle(2 * B);
        end
        send_frame(8'h81, 1'b1);
        idle(4);
        check_model("after_reset");

        // clr_rdy held across the set edge: the set wins, and one more cycle clears it
        model_clear();
        clr_rdy = 1'b1;
        found   = 1'b0;
        fork
            send_frame(8'h69, 1'b1);
            begin
                for (int i = 0; i < LAT + 20; i++) begin
                    idle(1);
                    if (rdy) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (found) model_clear();
                idle(1);
                clr_rdy = 1'b0;
            end
        join
        check("coincide_seen", {31'd0, found}, 32'd1);
        idle(4);
        check_model("coincide_cleared");

        // Break: RX held low for several frame times gives one framing error, then silence
        model_frame(8'h00, 1'b0, cyc);
        rx = 1'b0;
        idle(30 * B);
        rx = 1'b1;
        idle(2 * B);
        check_model("break");
        clr_pulse();
        idle(4);

        // Randomized frames, gaps and acknowledges
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, stop);
            gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
            if (gap > 0) idle(gap);
            if ($urandom_range(0, 2) == 0) clr_pulse();
        end

        // Drain the scoreboard, then compare the final state
        for (int i = 0; i < 4 * B && exp_q.size() != 0; i++) idle(1);
        check("drain", exp_q.size(), 32'd0);
        check_model("final_state");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
